// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK flip-flops with enable, up/down count, parallel load and cascade tc.
// Optional per-bit rise/fall event pulses are enabled by defining JKREG_EDGE_DETECT_EN.
module jk_register_bank #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_down;
  logic [WIDTH-1:0] q_next;
  logic             carry_up;
  logic             carry_down;

  // Counting is a ripple of JK toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_up       = '0;
    t_down     = '0;
    carry_up   = 1'b1;
    carry_down = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i]    = carry_up;
      t_down[i]  = carry_down;
      carry_up   = carry_up & q[i];
      carry_down = carry_down & ~q[i];
    end
  end

  always_comb begin
    q_next = q;
    case (mode)
      MODE_JK:   q_next = (j & ~q) | (~k & q);
      MODE_UP:   q_next = q ^ t_up;
      MODE_DOWN: q_next = q ^ t_down;
      MODE_LOAD: q_next = d;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= q_next;
    end
  end

  assign tc = en & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DOWN) & ~(|q)));

`ifdef JKREG_EDGE_DETECT_EN
  logic [WIDTH-1:0] q_new;

  assign q_new = en ? q_next : q;

  // Pulses line up with the cycle in which the new q is visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_rise <= '0;
      q_fall <= '0;
    end else begin
      q_rise <= ~q & q_new;
      q_fall <= q & ~q_new;
    end
  end
`else
  assign q_rise = '0;
  assign q_fall = '0;
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// Bench for jk_register_bank (WIDTH=4): directed vector table, edge-pulse sequence and
// randomized traffic against an arithmetic reference model.
module tb_jk_register_bank;

`ifdef JKREG_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] j = '0, k = '0, d = '0;
  logic [3:0] q, q_rise, q_fall, qa, qa_rise, qa_fall;
  logic       tc, tca;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_q, m_qa, m_rise, m_fall;
  bit         known = 1'b0;

  jk_register_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q), .tc(tc), .q_rise(q_rise), .q_fall(q_fall)
  );

  jk_register_bank #(.WIDTH(4), .RST_VAL(4'hA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(qa), .tc(tca), .q_rise(qa_rise), .q_fall(qa_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] m;
    logic [3:0] jj;
    logic [3:0] kk;
    logic [3:0] dd;
    logic [3:0] exp_q;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic tc_of(input logic [3:0] qq, input logic e, input logic [1:0] m);
    return e && ((m == 2'd1 && qq == 4'hF) || (m == 2'd2 && qq == 4'h0));
  endfunction

  function automatic logic [3:0] next_of(input logic [3:0] qq, input logic r, input logic e,
                                         input logic [1:0] m, input logic [3:0] jj,
                                         input logic [3:0] kk, input logic [3:0] dd,
                                         input logic [3:0] rv);
    logic [3:0] n;
    if (!r) return rv;
    if (!e) return qq;
    n = qq;
    case (m)
      2'd0: for (int b = 0; b < 4; b++)
              case ({jj[b], kk[b]})
                2'b01: n[b] = 1'b0;
                2'b10: n[b] = 1'b1;
                2'b11: n[b] = ~qq[b];
                default: n[b] = qq[b];
              endcase
      2'd1: n = 4'((int'(qq) + 1) % 16);
      2'd2: n = 4'((int'(qq) + 15) % 16);
      default: n = dd;
    endcase
    return n;
  endfunction

  task automatic apply(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd);
    logic [3:0] nq;
    @(negedge clk);
    rst = r; en = e; mode = m; j = jj; k = kk; d = dd;
    #1;
    if (known) chk("tc_pre_edge", {3'b0, tc}, {3'b0, tc_of(m_q, e, m)});
    nq = next_of(m_q, r, e, m, jj, kk, dd, 4'h0);
    if (!r || !EDGE) begin
      m_rise = 4'h0;
      m_fall = 4'h0;
    end else begin
      m_rise = ~m_q & nq;
      m_fall = m_q & ~nq;
    end
    m_q  = nq;
    m_qa = next_of(m_qa, r, e, m, jj, kk, dd, 4'hA);
    if (!r) known = 1'b1;
    @(posedge clk);
    #1;
    if (known) begin
      chk("q", q, m_q);
      chk("tc", {3'b0, tc}, {3'b0, tc_of(m_q, e, m)});
      chk("q_rise", q_rise, m_rise);
      chk("q_fall", q_fall, m_fall);
      chk("q_rstval_a", qa, m_qa);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                              input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd,
                              input logic [3:0] eq, input logic et);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.jj = jj; v.kk = kk; v.dd = dd; v.exp_q = eq; v.exp_tc = et;
    return v;
  endfunction

  initial begin
    // reset with count-up selected
    vecs.push_back(mk(0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    // JK mode
    vecs.push_back(mk(1, 1, 2'd0, 4'b0011, 4'b0000, 4'h0, 4'b0011, 0));
    vecs.push_back(mk(1, 1, 2'd0, 4'b1111, 4'b1111, 4'h0, 4'b1100, 0));
    vecs.push_back(mk(1, 1, 2'd0, 4'b0000, 4'b0100, 4'h0, 4'b1000, 0));
    vecs.push_back(mk(1, 0, 2'd0, 4'b1111, 4'b1111, 4'h0, 4'b1000, 0));
    // count up through wrap, with en dropped at F
    vecs.push_back(mk(1, 1, 2'd3, 4'h0, 4'h0, 4'hD, 4'hD, 0));
    vecs.push_back(mk(1, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'hE, 0));
    vecs.push_back(mk(1, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'hF, 1));
    vecs.push_back(mk(1, 0, 2'd1, 4'h0, 4'h0, 4'h0, 4'hF, 0));
    vecs.push_back(mk(1, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(1, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    // count down, switch to up at 0
    vecs.push_back(mk(1, 1, 2'd3, 4'h0, 4'h0, 4'h2, 4'h2, 0));
    vecs.push_back(mk(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    vecs.push_back(mk(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 1));
    vecs.push_back(mk(1, 1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    // count down through wrap
    vecs.push_back(mk(1, 1, 2'd3, 4'h0, 4'h0, 4'h1, 4'h1, 0));
    vecs.push_back(mk(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 1));
    vecs.push_back(mk(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 4'hF, 0));
    vecs.push_back(mk(1, 1, 2'd2, 4'h0, 4'h0, 4'h0, 4'hE, 0));
    // load, repeated load, reset beats load
    vecs.push_back(mk(1, 1, 2'd3, 4'hF, 4'hF, 4'h9, 4'h9, 0));
    vecs.push_back(mk(1, 1, 2'd3, 4'h0, 4'h0, 4'h9, 4'h9, 0));
    vecs.push_back(mk(0, 1, 2'd3, 4'h0, 4'h0, 4'h9, 4'h0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].jj, vecs[i].kk, vecs[i].dd);
      chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      chk($sformatf("vec%0d_tc", i), {3'b0, tc}, {3'b0, vecs[i].exp_tc});
      if (i == 0) chk("rstval_a_first_edge", qa, 4'hA);
    end

    // edge pulses: 0101 -> 0110 then hold
    apply(1, 1, 2'd3, 4'h0, 4'h0, 4'b0101);
    apply(1, 1, 2'd0, 4'b0010, 4'b0001, 4'h0);
    chk("edge_q", q, 4'b0110);
    chk("edge_rise", q_rise, EDGE ? 4'b0010 : 4'b0000);
    chk("edge_fall", q_fall, EDGE ? 4'b0001 : 4'b0000);
    apply(1, 1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("edge_rise_hold", q_rise, 4'b0000);
    chk("edge_fall_hold", q_fall, 4'b0000);

    // reset that changes q gives no pulse
    apply(1, 1, 2'd3, 4'h0, 4'h0, 4'hF);
    apply(0, 1, 2'd3, 4'h0, 4'h0, 4'hF);
    chk("rst_no_fall", q_fall, 4'b0000);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
